// File: rtl/neuron_pkg.sv
// Shared constants, types and the leak/integrate arithmetic for the neuron sheet.
package neuron_pkg;

  localparam int DEF_N_NEURONS  = 8;
  localparam int DEF_V_WIDTH    = 16;
  localparam int DEF_I_WIDTH    = 16;
  localparam int DEF_THRESHOLD  = 1000;
  localparam int DEF_LEAK_SHIFT = 4;
  localparam int DEF_REFRACT    = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int ID_WIDTH  = 8;
  localparam int REF_WIDTH = 4;

  typedef logic [ID_WIDTH-1:0]  spike_id_t;
  typedef logic [REF_WIDTH-1:0] ref_t;

  // v - (v >> leak_shift) + cur, saturated to 2^v_width - 1 (v_width <= 31).
  function automatic logic [31:0] leak_add_sat(input logic [31:0] v,
                                               input logic [31:0] cur,
                                               input int unsigned v_width,
                                               input int unsigned leak_shift);
    logic [32:0] sum;
    logic [32:0] sat_max;
    sum     = {1'b0, v} - ({1'b0, v} >> leak_shift) + {1'b0, cur};
    sat_max = (33'd1 << v_width) - 33'd1;
    if (sum > sat_max) begin
      return sat_max[31:0];
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/neuron_sheet_spike_fifo.sv
// Small circular buffer for spike address events; a push into a full buffer
// is still accepted when an entry leaves in the same cycle.
module spike_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/neuron_sheet.sv
// Time-multiplexed sheet of leaky integrate-and-fire neurons: one shared
// update datapath sweeps the per-neuron state, spikes queue as neuron IDs.
module neuron_sheet
  import neuron_pkg::*;
#(
  parameter int N_NEURONS  = DEF_N_NEURONS,
  parameter int V_WIDTH    = DEF_V_WIDTH,
  parameter int I_WIDTH    = DEF_I_WIDTH,
  parameter int THRESHOLD  = DEF_THRESHOLD,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRACT    = DEF_REFRACT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [N_NEURONS*I_WIDTH-1:0] input_current,
  output logic                         spike_valid,
  input  logic                         spike_ready,
  output logic [ID_WIDTH-1:0]          spike_id,
  input  logic [ID_WIDTH-1:0]          probe_sel,
  output logic [V_WIDTH-1:0]           v_out,
  output logic                         sweep_done,
  output logic                         overflow
);

  localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX     = IDX_W'(N_NEURONS - 1);
  localparam logic [V_WIDTH:0]     THRESH       = (V_WIDTH + 1)'(THRESHOLD);
  localparam logic [REF_WIDTH-1:0] REFRACT_INIT = REF_WIDTH'(REFRACT);

  logic [V_WIDTH-1:0]   v_mem   [N_NEURONS];
  logic [REF_WIDTH-1:0] ref_mem [N_NEURONS];
  logic [I_WIDTH-1:0]   cur_arr [N_NEURONS];
  logic [IDX_W-1:0]     idx_reg;
  logic [V_WIDTH-1:0]   v_out_reg;
  logic                 sweep_done_reg;
  logic                 overflow_reg;

  logic [V_WIDTH-1:0]   cur_v;
  logic [REF_WIDTH-1:0] cur_ref;
  logic [V_WIDTH-1:0]   vn;
  logic                 is_refract;
  logic                 fire;
  logic [V_WIDTH-1:0]   v_wr;
  logic [REF_WIDTH-1:0] ref_wr;

  logic                 probe_in_range;
  logic [IDX_W-1:0]     probe_idx;
  logic [V_WIDTH-1:0]   probe_val;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [IDX_W-1:0]     fifo_head;
  logic                 pop;

  for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_cur
    assign cur_arr[gi] = input_current[gi*I_WIDTH +: I_WIDTH];
  end

  assign cur_v      = v_mem[idx_reg];
  assign cur_ref    = ref_mem[idx_reg];
  assign vn         = V_WIDTH'(leak_add_sat(32'(cur_v), 32'(cur_arr[idx_reg]),
                                            V_WIDTH, LEAK_SHIFT));
  assign is_refract = (cur_ref != '0);
  assign fire       = en && !is_refract && ({1'b0, vn} >= THRESH);
  assign v_wr       = (is_refract || fire) ? '0 : vn;
  assign ref_wr     = is_refract ? cur_ref - 1'b1 : (fire ? REFRACT_INIT : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        v_mem[k]   <= '0;
        ref_mem[k] <= '0;
      end
      idx_reg <= '0;
    end else if (en) begin
      v_mem[idx_reg]   <= v_wr;
      ref_mem[idx_reg] <= ref_wr;
      idx_reg          <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
    end
  end

  // Probe forwards the value being written this cycle so v_out is never stale.
  assign probe_in_range = ({1'b0, probe_sel} < 9'(N_NEURONS));
  assign probe_idx      = probe_sel[IDX_W-1:0];

  always_comb begin
    probe_val = '0;
    if (probe_in_range) begin
      if (en && (probe_idx == idx_reg)) begin
        probe_val = v_wr;
      end else begin
        probe_val = v_mem[probe_idx];
      end
    end
  end

  assign pop = spike_valid && spike_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_out_reg      <= '0;
      sweep_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      v_out_reg      <= probe_val;
      sweep_done_reg <= en && (idx_reg == LAST_IDX);
      overflow_reg   <= overflow_reg | (fire && fifo_full && !pop);
    end
  end

  spike_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IDX_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fire),
    .din   (idx_reg),
    .full  (fifo_full),
    .pop   (pop),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign spike_valid = !fifo_empty;
  assign spike_id    = fifo_empty ? '0 : ID_WIDTH'(fifo_head);
  assign v_out       = v_out_reg;
  assign sweep_done  = sweep_done_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_neuron_sheet.sv
// Bench for neuron_sheet: two sheets (N=4/THR=100 and N=8/THR=65535) run against a
// per-cycle behavioural model plus directed literal expectations.
module tb_neuron_sheet;

  localparam int NA    = 4;
  localparam int NB    = 8;
  localparam int THR_A = 100;
  localparam int THR_B = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       spike_ready = 1'b0;
  logic [7:0] probe_sel = 8'd0;
  logic [15:0] cur_a [NA];
  logic [15:0] cur_b [NB];
  logic [NA*16-1:0] bus_a;
  logic [NB*16-1:0] bus_b;

  logic       valid_a, sweep_a, ovf_a;
  logic [7:0] id_a;
  logic [15:0] vout_a;
  logic       valid_b, sweep_b, ovf_b;
  logic [7:0] id_b;
  logic [15:0] vout_b;

  always_comb begin
    bus_a = '0;
    for (int k = 0; k < NA; k++) bus_a[k*16 +: 16] = cur_a[k];
  end
  always_comb begin
    bus_b = '0;
    for (int k = 0; k < NB; k++) bus_b[k*16 +: 16] = cur_b[k];
  end

  neuron_sheet #(.N_NEURONS(NA), .V_WIDTH(16), .I_WIDTH(16), .THRESHOLD(THR_A),
                 .LEAK_SHIFT(4), .REFRACT(2), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .en(en), .input_current(bus_a),
    .spike_valid(valid_a), .spike_ready(spike_ready), .spike_id(id_a),
    .probe_sel(probe_sel), .v_out(vout_a), .sweep_done(sweep_a), .overflow(ovf_a));

  neuron_sheet #(.N_NEURONS(NB), .V_WIDTH(16), .I_WIDTH(16), .THRESHOLD(THR_B),
                 .LEAK_SHIFT(4), .REFRACT(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .en(en), .input_current(bus_b),
    .spike_valid(valid_b), .spike_ready(spike_ready), .spike_id(id_b),
    .probe_sel(probe_sel), .v_out(vout_b), .sweep_done(sweep_b), .overflow(ovf_b));

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int mv    [2][8];
  int mref  [2][8];
  int midx  [2];
  int movf  [2];
  int msweep[2];
  int mvout [2];
  int q0[$];
  int q1[$];

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 8; k++) begin
        mv[m][k] = 0;
        mref[m][k] = 0;
      end
      midx[m] = 0; movf[m] = 0; msweep[m] = 0; mvout[m] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(input int m);
    int n, th, qs, k, i_cur, vn;
    n  = (m == 0) ? NA : NB;
    th = (m == 0) ? THR_A : THR_B;
    qs = (m == 0) ? q0.size() : q1.size();
    if (spike_ready && qs > 0) begin
      if (m == 0) q0.delete(0); else q1.delete(0);
      qs--;
    end
    msweep[m] = 0;
    if (en) begin
      k = midx[m];
      if (mref[m][k] > 0) begin
        mref[m][k]--;
        mv[m][k] = 0;
      end else begin
        if (m == 0) i_cur = int'(cur_a[k]); else i_cur = int'(cur_b[k]);
        vn = mv[m][k] - mv[m][k] / 16 + i_cur;
        if (vn > 65535) vn = 65535;
        if (vn >= th) begin
          mv[m][k] = 0;
          mref[m][k] = 2;
          if (qs < 4) begin
            if (m == 0) q0.push_back(k); else q1.push_back(k);
          end else begin
            movf[m] = 1;
          end
        end else begin
          mv[m][k] = vn;
        end
      end
      msweep[m] = (k == n - 1) ? 1 : 0;
      midx[m] = (k + 1) % n;
    end
    mvout[m] = (int'(probe_sel) < n) ? mv[m][probe_sel] : 0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_clear();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge clk) begin
    if (reset && chk_en) begin
      check("cmp_valid_a", 32'(valid_a), (q0.size() > 0) ? 1 : 0);
      if (q0.size() > 0) check("cmp_id_a", 32'(id_a), q0[0]);
      check("cmp_vout_a", 32'(vout_a), mvout[0]);
      check("cmp_sweep_a", 32'(sweep_a), msweep[0]);
      check("cmp_ovf_a", 32'(ovf_a), movf[0]);
      check("cmp_valid_b", 32'(valid_b), (q1.size() > 0) ? 1 : 0);
      if (q1.size() > 0) check("cmp_id_b", 32'(id_b), q1[0]);
      check("cmp_vout_b", 32'(vout_b), mvout[1]);
      check("cmp_sweep_b", 32'(sweep_b), msweep[1]);
      check("cmp_ovf_b", 32'(ovf_b), movf[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step_cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    en = 1'b0;
    spike_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin : stim
    int got [7];
    int exp1 [7];
    int vis, ev, ev_id, ne, pulses_a, pulses_b;
    exp1 = '{30, 59, 86, 0, 0, 0, 30};
    for (int k = 0; k < NA; k++) cur_a[k] = 16'd0;
    for (int k = 0; k < NB; k++) cur_b[k] = 16'd0;
    probe_sel = 8'd2;

    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_valid_a", 32'(valid_a), 0);
    check("rst_id_a", 32'(id_a), 0);
    check("rst_vout_a", 32'(vout_a), 0);
    check("rst_sweep_a", 32'(sweep_a), 0);
    check("rst_ovf_b", 32'(ovf_b), 0);
    reset = 1'b1;
    chk_en = 1'b1;

    // single firing neuron
    cur_a[2] = 16'd30;
    en = 1'b1;
    spike_ready = 1'b1;
    vis = 0; ev = 0; ev_id = -1;
    for (int c = 0; c < 28; c++) begin
      step_cyc();
      if (c % 4 == 2 && vis < 7) begin
        got[vis] = int'(vout_a);
        vis++;
      end
      if (valid_a) begin
        ev++;
        ev_id = int'(id_a);
      end
    end
    for (int v = 0; v < 7; v++) check($sformatf("fire_visit%0d", v), got[v], exp1[v]);
    check("fire_event_count", ev, 1);
    check("fire_event_id", ev_id, 2);

    // out-of-range probe
    cur_a[2] = 16'd0;
    en = 1'b0;
    probe_sel = 8'd9;
    step_cyc();
    check("probe_oob_a", 32'(vout_a), 0);
    check("probe_oob_b", 32'(vout_b), 0);

    // saturation
    do_reset();
    probe_sel = 8'd0;
    cur_b[0] = 16'h8000;
    en = 1'b1;
    spike_ready = 1'b1;
    step_cyc();
    check("sat_first_v", 32'(vout_b), 32'h8000);
    cur_b[0] = 16'hFFFF;
    repeat (7) step_cyc();
    step_cyc();
    check("sat_fire_valid", 32'(valid_b), 1);
    check("sat_fire_id", 32'(id_b), 0);
    check("sat_no_wrap_v", 32'(vout_b), 0);
    cur_b[0] = 16'd0;

    // FIFO full with overflow
    do_reset();
    for (int k = 0; k < NB; k++) cur_b[k] = 16'hFFFF;
    en = 1'b1;
    repeat (4) step_cyc();
    check("full_ovf_before", 32'(ovf_b), 0);
    check("full_head", 32'(id_b), 0);
    step_cyc();
    check("full_ovf_set", 32'(ovf_b), 1);
    en = 1'b0;
    spike_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(valid_b), 1);
      check("drain_id", 32'(id_b), i);
      step_cyc();
    end
    check("drain_empty", 32'(valid_b), 0);
    check("ovf_sticky", 32'(ovf_b), 1);

    // simultaneous push and pop on a full FIFO
    do_reset();
    en = 1'b1;
    repeat (4) step_cyc();
    spike_ready = 1'b1;
    step_cyc();
    en = 1'b0;
    check("pushpop_ovf", 32'(ovf_b), 0);
    for (int i = 1; i <= 4; i++) begin
      check("pushpop_id", 32'(id_b), i);
      step_cyc();
    end
    check("pushpop_empty", 32'(valid_b), 0);

    // enable toggling and sweep flag
    do_reset();
    for (int k = 0; k < NB; k++) cur_b[k] = 16'd0;
    spike_ready = 1'b1;
    ne = 0; pulses_a = 0; pulses_b = 0;
    for (int c = 0; c < 32; c++) begin
      en = (c % 2 == 0);
      step_cyc();
      if (en) ne++;
      if (sweep_b) begin
        pulses_b++;
        check("sweep_b_position", ne % 8, 0);
      end
      if (sweep_a) pulses_a++;
    end
    check("sweep_b_pulses", pulses_b, 2);
    check("sweep_a_pulses", pulses_a, 4);

    // asynchronous reset mid-operation
    do_reset();
    for (int k = 0; k < NB; k++) cur_b[k] = 16'hFFFF;
    cur_a[1] = 16'd10;
    probe_sel = 8'd1;
    en = 1'b1;
    spike_ready = 1'b0;
    repeat (5) step_cyc();
    check("pre_rst_valid", 32'(valid_b), 1);
    check("pre_rst_ovf", 32'(ovf_b), 1);
    check("pre_rst_vout_a", 32'(vout_a), 10);
    #1;
    reset = 1'b0;
    #1;
    check("async_valid_b", 32'(valid_b), 0);
    check("async_id_b", 32'(id_b), 0);
    check("async_ovf_b", 32'(ovf_b), 0);
    check("async_vout_a", 32'(vout_a), 0);
    check("async_sweep_b", 32'(sweep_b), 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    step_cyc();
    check("post_rst_valid", 32'(valid_b), 1);
    check("post_rst_first_id", 32'(id_b), 0);
    en = 1'b0;
    step_cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
